mem_lsu: RTL and testbench
==========================

# mem_lsu

Memory-stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB register `wb_dff`. It converts the MEM-stage load/store request into a req/gnt/rvalid transaction on the data-memory port and generates byte enables and store-data lane replication. It extracts and sign- or zero-extends load data into `data_out`, which feeds `wb_dff`. It raises `stall_m` to freeze the pipeline while an access is outstanding.

## Interface
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `ADDR_WIDTH`, 32, byte-address width.
- `TIMEOUT_CYCLES`, 255, cycles spent in REQ/WAIT before an access is aborted; must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserted when `rst`=0.
- `mem_valid`  in  1  a valid instruction occupies MEM.
- `mem_rem`  in  1  instruction is a load.
- `mem_wem`  in  1  instruction is a store; never high together with `mem_rem`.
- `mem_ctrm`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `alu_resultm`  in  ADDR_WIDTH  effective byte address.
- `rs2_datam`  in  DATA_WIDTH  store data.
- `data_out`  out  DATA_WIDTH  formatted load result to `wb_dff`.
- `stall_m`  out  1  freeze IF..MEM this cycle.
- `misalign`  out  1  one-cycle misaligned-access flag.
- `bus_err`  out  1  one-cycle timeout flag.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_WIDTH  word address; bits [1:0] are forced to 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  DATA_WIDTH  read data.

## Operation
- An access is `acc = mem_valid & (mem_rem | mem_wem)`. A store is complete in the cycle that `dmem_req & dmem_gnt` is true. A load is complete in the cycle that `dmem_rvalid` is sampled in WAIT.
- FSM states:
  - IDLE:
    - `dmem_req = acc`, combinational.
    - gnt with a store: done, stay in IDLE.
    - gnt with a load: go to WAIT.
    - no gnt: go to REQ.
  - REQ: `dmem_req`=1. On gnt, a store returns to IDLE and a load goes to WAIT.
  - WAIT: `dmem_req`=0. `dmem_rvalid` completes the load and returns to IDLE.
- `stall_m = acc & ~complete & ~abort`. Address, control and store data are held stable by the frozen EX/MEM register.
- Byte enables and store lanes, with `a = alu_resultm[1:0]`:
  - B: `be = 1<<a`, data = byte replicated ×4.
  - H: `be` = 0011 (a[1]=0) or 1100 (a[1]=1), data = halfword replicated ×2.
  - W: `be` = 1111.
- Load extraction:
  - B/BU: byte `a` of `dmem_rdata`.
  - H/HU: halfword `a[1]` of `dmem_rdata`.
  - Sign-extend for B/H; zero-extend for BU/HU.
- `data_out` holds the formatted value only in the load-complete cycle and is 0 otherwise.
- Timeout:
  - The counter clears on entry to REQ/WAIT and increments each cycle in those states.
  - When it reaches `TIMEOUT_CYCLES` without completion: `bus_err`=1, `stall_m`=0, `data_out`=0, `dmem_req`=0, next state IDLE.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- `dmem_rvalid` is ignored outside WAIT. `dmem_gnt` is ignored while `dmem_req`=0.
- If completion and timeout occur in the same cycle, completion wins and `bus_err` stays 0.

## Timing
- While `rst`=0:
  - FSM = IDLE and counter = 0.
  - All outputs are 0: `data_out`, `stall_m`, `misalign`, `bus_err`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`.
- Reset taken mid-access abandons the access with no completion and no flags.
- Store with same-cycle gnt: 0 stall cycles.
- Load: gnt in cycle N, rvalid earliest in N+1. Minimum stall is 1 cycle (cycle N); `data_out` is valid in the rvalid cycle.
- Memory must not assert `dmem_rvalid` in its grant cycle.
- A back-to-back access in the cycle after completion starts a new transaction from IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H/HU with `a[0]`=1, or W with `a`≠0, issues no request.
  - `misalign`=1 for that cycle, `stall_m`=0, `data_out`=0, and the state stays IDLE.
- Not defined:
  - `misalign` is tied to 0.
  - The address low bits are cleared (H: bit 0; W: bits 1:0) before computing `be` and lanes, and the access proceeds normally.

## Test plan
- SW addr 0x104, data 0xDEADBEEF, gnt same cycle → `be`=1111, `dmem_addr`=0x104, `stall_m` 0 throughout.
- LB addr 0x103, gnt in cycle N, rvalid in N+2 with rdata 0x80FF_FFFF → `stall_m` high for 2 cycles; `data_out`=0xFFFF_FF80 in N+2.
- LHU addr 0x202, rdata 0x8001_1234 → `be`=1100, `data_out`=0x0000_8001. SB addr 0x201 with rs2 0xAB → `be`=0010, `dmem_wdata`=0xABABABAB.
- LW with gnt held low, `TIMEOUT_CYCLES`=4 → `bus_err` pulses exactly once in the 4th REQ cycle, `stall_m` drops, `dmem_req` falls, FSM back to IDLE.
- LW addr 0x102:
  - With macro: `misalign`=1 for one cycle, `dmem_req`=0.
  - Without macro: `dmem_addr`=0x100, `be`=1111.
- `rst` pulled low while in WAIT → all outputs 0 immediately. After release, a late `dmem_rvalid` is ignored and the next load completes normally.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu -- memory-stage load/store unit.
//
// Turns the MEM-stage load/store request into a req/gnt/rvalid transaction on
// the data-memory port. Generates byte enables and lane-replicated store
// data, and formats returned load data (byte/halfword extraction with sign or
// zero extension) for the MEM/WB register. Holds the pipeline with stall_m
// while an access is outstanding, and aborts an access that is neither granted
// nor answered within TIMEOUT_CYCLES cycles of REQ/WAIT.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W accesses issue no request and pulse misalign.
//   undefined : misalign is tied to 0; the low address bits are cleared and
//               the access proceeds.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   mem_valid/rem/wem     MEM-stage valid, load, store
//   mem_ctrm[2:0]         funct3 (B, H, W, BU, HU)
//   alu_resultm           effective byte address
//   rs2_datam             store data
//   data_out              formatted load result (valid in load-complete cycle)
//   stall_m               freeze IF..MEM
//   misalign, bus_err     one-cycle misaligned / timeout flags
//   dmem_req/we/addr/be/wdata   request side of the data-memory port
//   dmem_gnt/rvalid/rdata       response side of the data-memory port

module mem_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_rem,
  input  logic                  mem_wem,
  input  logic [2:0]            mem_ctrm,
  input  logic [ADDR_WIDTH-1:0] alu_resultm,
  input  logic [DATA_WIDTH-1:0] rs2_datam,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  stall_m,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires in the cycle the counter would reach TIMEOUT_CYCLES, i.e. the
  // TIMEOUT_CYCLES-th cycle spent in REQ/WAIT (counter starts at 0 on entry).
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        a;
  logic [1:0]        eff_a;
  logic              acc;
  logic              trap;
  logic              limit;
  logic              req_int;
  logic              gnt_ok;
  logic              store_done;
  logic              load_done;
  logic              complete;
  logic              abort;
  logic [3:0]        be_int;
  logic [DATA_WIDTH-1:0] wdata_int;
  logic [DATA_WIDTH-1:0] load_val;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              sext;

  assign acc = mem_valid & (mem_rem | mem_wem);
  assign a   = alu_resultm[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  // A misaligned access is refused outright from IDLE; it never reaches REQ.
  assign eff_a = a;
  assign trap  = acc & (state == S_IDLE) &
                 (((mem_ctrm[1:0] == 2'b01) & a[0]) |
                  ((mem_ctrm[1:0] == 2'b10) & (a != 2'b00)));
`else
  // Without the trap, the offending low address bits are simply dropped.
  always_comb begin
    eff_a = a;
    if (mem_ctrm[1:0] == 2'b01)
      eff_a = {a[1], 1'b0};
    else if (mem_ctrm[1:0] == 2'b10)
      eff_a = 2'b00;
  end
  assign trap = 1'b0;
`endif

  assign limit = (state != S_IDLE) && (cnt == CNT_LIMIT);

  // Request is combinational from IDLE so a same-cycle grant costs no stall.
  // In the final REQ cycle the request is withdrawn, so a timeout there can
  // never race a grant.
  always_comb begin
    req_int = 1'b0;
    case (state)
      S_IDLE:  req_int = acc & ~trap;
      S_REQ:   req_int = ~limit;
      default: req_int = 1'b0;
    endcase
  end

  assign gnt_ok     = req_int & dmem_gnt;
  assign store_done = gnt_ok & mem_wem;
  assign load_done  = (state == S_WAIT) & dmem_rvalid;
  assign complete   = store_done | load_done;
  assign abort      = limit & ~complete;

  always_comb begin
    be_int    = 4'b1111;
    wdata_int = rs2_datam;
    case (mem_ctrm[1:0])
      2'b00: begin
        be_int    = 4'b0001 << eff_a;
        wdata_int = {4{rs2_datam[7:0]}};
      end
      2'b01: begin
        be_int    = eff_a[1] ? 4'b1100 : 4'b0011;
        wdata_int = {2{rs2_datam[15:0]}};
      end
      default: ;
    endcase
  end

  // funct3 bit 2 distinguishes the unsigned load variants.
  always_comb begin
    case (eff_a)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = eff_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    sext     = ~mem_ctrm[2];
    case (mem_ctrm[1:0])
      2'b00:   load_val = {{24{sext & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sext & half_sel[15]}}, half_sel};
      default: load_val = dmem_rdata;
    endcase
  end

  // Every output is forced low while reset is asserted, independent of the
  // (combinational) inputs feeding it.
  assign dmem_req   = rst & req_int;
  assign dmem_we    = rst & req_int & mem_wem;
  assign dmem_addr  = (rst && req_int) ? {alu_resultm[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem_be    = (rst && req_int) ? be_int : 4'b0000;
  assign dmem_wdata = (rst && req_int) ? wdata_int : '0;
  assign data_out   = (rst && load_done) ? load_val : '0;
  assign stall_m    = rst & acc & ~complete & ~abort & ~trap;
  assign misalign   = rst & trap;
  assign bus_err    = rst & abort;

  // Transaction sequencer and timeout counter; the counter restarts on every
  // entry to REQ or WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_int && !store_done) begin
            state <= dmem_gnt ? S_WAIT : S_REQ;
            cnt   <= '0;
          end
        end
        S_REQ: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (gnt_ok) begin
            state <= mem_wem ? S_IDLE : S_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (load_done || abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu -- self-checking bench for mem_lsu (TIMEOUT_CYCLES = 4).
// Expected load results are queued when a load is launched and popped when
// the bench's memory model returns rvalid. Honours LSU_MISALIGN_TRAP_EN.

module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_rem;
  logic        mem_wem;
  logic [2:0]  mem_ctrm;
  logic [31:0] alu_resultm;
  logic [31:0] rs2_datam;
  logic [31:0] data_out;
  logic        stall_m;
  logic        misalign;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_rem(mem_rem), .mem_wem(mem_wem),
    .mem_ctrm(mem_ctrm), .alu_resultm(alu_resultm), .rs2_datam(rs2_datam),
    .data_out(data_out), .stall_m(stall_m), .misalign(misalign), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic re, input logic we,
                               input logic [2:0] ctr, input logic [31:0] addr,
                               input logic [31:0] wd);
    mem_valid   = v;
    mem_rem     = re;
    mem_wem     = we;
    mem_ctrm    = ctr;
    alu_resultm = addr;
    rs2_datam   = wd;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic doStore(input string tag, input logic [2:0] ctr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    applyStimulus(1'b1, 1'b0, 1'b1, ctr, addr, wd);
    dmem_gnt = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_req"},   32'(dmem_req), 32'd1);
    checkOutput({tag, "_we"},    32'(dmem_we), 32'd1);
    checkOutput({tag, "_addr"},  dmem_addr, exp_addr);
    checkOutput({tag, "_be"},    32'(dmem_be), 32'(exp_be));
    checkOutput({tag, "_wdata"}, dmem_wdata, exp_wdata);
    checkOutput({tag, "_stall"}, 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_after_req"},   32'(dmem_req), 32'd0);
    checkOutput({tag, "_after_stall"}, 32'(stall_m), 32'd0);
    @(posedge clk); #1;
  endtask

  // Load granted in its first cycle, then lat WAIT cycles before rvalid.
  task automatic doLoad(input string tag, input logic [2:0] ctr, input logic [31:0] addr,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] rdata, input logic [31:0] exp_data, input int lat);
    int stalls;
    logic [31:0] exp_val;
    applyStimulus(1'b1, 1'b1, 1'b0, ctr, addr, 32'h0);
    dmem_gnt = 1'b1;
    exp_q.push_back(exp_data);
    @(negedge clk);
    checkOutput({tag, "_req"},      32'(dmem_req), 32'd1);
    checkOutput({tag, "_we"},       32'(dmem_we), 32'd0);
    checkOutput({tag, "_addr"},     dmem_addr, exp_addr);
    checkOutput({tag, "_be"},       32'(dmem_be), 32'(exp_be));
    checkOutput({tag, "_misalign"}, 32'(misalign), 32'd0);
    checkOutput({tag, "_data0"},    data_out, 32'd0);
    stalls = int'(stall_m);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_wait_req"}, 32'(dmem_req), 32'd0);
      stalls += int'(stall_m);
    end
    @(posedge clk); #1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    exp_val = exp_q.pop_front();
    checkOutput({tag, "_data"},    data_out, exp_val);
    checkOutput({tag, "_stall"},   32'(stall_m), 32'd0);
    checkOutput({tag, "_buserr"},  32'(bus_err), 32'd0);
    checkOutput({tag, "_nstalls"}, 32'(stalls), 32'(lat + 1));
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({tag, "_data_after"}, data_out, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    int pulse_at;

    // Reset with an access presented: every output must still read 0.
    rst         = 1'b0;
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h104, 32'hFFFF_FFFF);
    #2;
    checkOutput("rst_req",   32'(dmem_req), 32'd0);
    checkOutput("rst_stall", 32'(stall_m), 32'd0);
    checkOutput("rst_addr",  dmem_addr, 32'd0);
    checkOutput("rst_be",    32'(dmem_be), 32'd0);
    checkOutput("rst_data",  data_out, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    rst         = 1'b1;
    @(posedge clk); #1;

    $display("[TB] stores and loads");
    doStore("sw", 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h104, 4'b1111, 32'hDEAD_BEEF);
    doLoad("lb", 3'b000, 32'h103, 32'h100, 4'b1000, 32'h80FF_FFFF, 32'hFFFF_FF80, 1);
    doLoad("lhu", 3'b101, 32'h202, 32'h200, 4'b1100, 32'h8001_1234, 32'h0000_8001, 0);
    doStore("sb", 3'b000, 32'h201, 32'h0000_00AB, 32'h200, 4'b0010, 32'hABAB_ABAB);
    doStore("sh", 3'b001, 32'h206, 32'h1234_5678, 32'h204, 4'b1100, 32'h5678_5678);
    doLoad("lh", 3'b001, 32'h102, 32'h100, 4'b1100, 32'h8001_1234, 32'hFFFF_8001, 2);
    doLoad("lbu", 3'b100, 32'h101, 32'h100, 4'b0010, 32'h0000_F200, 32'h0000_00F2, 0);
    // rvalid in the 4th WAIT cycle: completion beats the timeout.
    doLoad("lw_edge", 3'b010, 32'h108, 32'h108, 4'b1111, 32'h1234_5678, 32'h1234_5678, 3);

    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("to_idle_req",   32'(dmem_req), 32'd1);
    checkOutput("to_idle_stall", 32'(stall_m), 32'd1);
    pulses   = 0;
    pulse_at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (pulses != 0)
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      if (bus_err) begin
        pulses++;
        if (pulse_at == 0) pulse_at = k;
        checkOutput("to_stall", 32'(stall_m), 32'd0);
        checkOutput("to_req",   32'(dmem_req), 32'd0);
        checkOutput("to_data",  data_out, 32'd0);
      end
    end
    checkOutput("to_pulses", 32'(pulses), 32'd1);
    checkOutput("to_cycle",  32'(pulse_at), 32'd4);
    checkOutput("to_after_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    doLoad("lw_post_to", 3'b010, 32'h10C, 32'h10C, 4'b1111, 32'hA5A5_0001, 32'hA5A5_0001, 0);

    $display("[TB] misaligned word");
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("mis_flag",  32'(misalign), 32'd1);
    checkOutput("mis_req",   32'(dmem_req), 32'd0);
    checkOutput("mis_stall", 32'(stall_m), 32'd0);
    checkOutput("mis_data",  data_out, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("mis_flag_after", 32'(misalign), 32'd0);
    @(posedge clk); #1;
`else
    doLoad("lw_mis", 3'b010, 32'h102, 32'h100, 4'b1111, 32'h1122_3344, 32'h1122_3344, 0);
    doLoad("lh_mis", 3'b001, 32'h103, 32'h100, 4'b1100, 32'hFEDC_0000, 32'hFFFF_FEDC, 1);
`endif

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #2;
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    #1;
    checkOutput("rw_data",   data_out, 32'd0);
    checkOutput("rw_stall",  32'(stall_m), 32'd0);
    checkOutput("rw_req",    32'(dmem_req), 32'd0);
    checkOutput("rw_we",     32'(dmem_we), 32'd0);
    checkOutput("rw_addr",   dmem_addr, 32'd0);
    checkOutput("rw_be",     32'(dmem_be), 32'd0);
    checkOutput("rw_wdata",  dmem_wdata, 32'd0);
    checkOutput("rw_buserr", 32'(bus_err), 32'd0);
    checkOutput("rw_mis",    32'(misalign), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rw_late_rvalid_data", data_out, 32'd0);
    checkOutput("rw_late_rvalid_stall", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    doLoad("lw_post_rst", 3'b010, 32'h300, 32'h300, 4'b1111, 32'h1357_9BDF, 32'h1357_9BDF, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
